// File: rtl/cnn_params_pkg.sv
// Shared CNN stream parameters: map size defaults, streamer FSM encoding,
// and padded output geometry. FM_ZERO_PAD_EN adds a one-pixel zero border.
package cnn_params_pkg;

   localparam int unsigned FmDataWidth = 32;
   localparam int unsigned FmWidth     = 7;
   localparam int unsigned FmHeight    = 7;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StDone   = 2'd2
   } fm_state_e;

   // Streamed dimension for a stored dimension (border on both sides when padding)
   function automatic int unsigned out_dim(input int unsigned dim);
`ifdef FM_ZERO_PAD_EN
      return dim + 2;
`else
      return dim;
`endif
   endfunction

endpackage

// File: rtl/fm_stream_reader_if.sv
// Pixel stream handshake: producer drives data/valid/last, consumer drives ready.
interface fm_stream_reader_if #(
   parameter int unsigned DATA_WIDTH = cnn_params_pkg::FmDataWidth
) ();

   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  last_out;
   logic                  ready_in;

   modport master (
      output data_out,
      output valid_out,
      output last_out,
      input  ready_in
   );

   modport slave (
      input  data_out,
      input  valid_out,
      input  last_out,
      output ready_in
   );

endinterface

// File: rtl/fm_mem.sv
// Feature-map storage: synchronous write, combinational read, no reset.
module fm_mem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned Depth      = 49,
   parameter int unsigned AddrWidth  = 6
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [AddrWidth-1:0]  wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [AddrWidth-1:0]  rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [DATA_WIDTH-1:0] mem_q [Depth];

   // Store in-range writes only; addresses past the map are silently dropped
   always_ff @(posedge clk_i) begin
      if (wr_en_i && (32'(wr_addr_i) < Depth)) begin
         mem_q[wr_addr_i[IdxW-1:0]] <= wr_data_i;
      end
   end

   // Asynchronous read, zero for out-of-range addresses
   always_comb begin
      rd_data_o = '0;
      if (32'(rd_addr_i) < Depth) begin
         rd_data_o = mem_q[rd_addr_i[IdxW-1:0]];
      end
   end

endmodule

// File: rtl/fm_stream_reader.sv
// Raster-order feature-map streamer feeding the 3x3 line_buffer.
// Optional macro FM_ZERO_PAD_EN: stream a one-pixel zero border around the map.
module fm_stream_reader
   import cnn_params_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FmDataWidth,
   parameter int unsigned WIDTH      = FmWidth,
   parameter int unsigned HEIGHT     = FmHeight,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   fm_stream_reader_if.master    strm
);

   localparam int unsigned OutW  = out_dim(WIDTH);
   localparam int unsigned OutH  = out_dim(HEIGHT);
   localparam int unsigned Depth = WIDTH * HEIGHT;
   localparam int unsigned ColW  = (OutW > 1) ? $clog2(OutW) : 1;
   localparam int unsigned RowW  = (OutH > 1) ? $clog2(OutH) : 1;

   fm_state_e             state_q, state_d;
   logic [RowW-1:0]       row_q, row_d, nxt_row;
   logic [ColW-1:0]       col_q, col_d, nxt_col;
   logic [DATA_WIDTH-1:0] data_q, data_d, rd_data, pix;
   logic                  valid_q, valid_d, last_q, last_d;
   logic                  nxt_last;
   logic [ADDR_WIDTH-1:0] rd_addr;

   fm_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .Depth      (Depth),
      .AddrWidth  (ADDR_WIDTH)
   ) u_fm_mem (
      .clk_i     (clk),
      .wr_en_i   (wr_en && (state_q == StIdle)),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // Position of the pixel to load next: (0,0) when starting, else raster successor
   always_comb begin
      nxt_row = '0;
      nxt_col = '0;
      if (state_q == StStream) begin
         if (col_q == ColW'(OutW - 1)) begin
            nxt_row = row_q + 1'b1;
         end else begin
            nxt_row = row_q;
            nxt_col = col_q + 1'b1;
         end
      end
      nxt_last = (nxt_row == RowW'(OutH - 1)) && (nxt_col == ColW'(OutW - 1));
   end

   // Map the output position onto a storage word
   always_comb begin
`ifdef FM_ZERO_PAD_EN
      rd_addr = ADDR_WIDTH'((32'(nxt_row) - 32'd1) * WIDTH + 32'(nxt_col) - 32'd1);
      pix     = rd_data;
      // Border positions are constant zero and never use the storage word
      if ((nxt_row == '0) || (nxt_row == RowW'(OutH - 1)) ||
          (nxt_col == '0) || (nxt_col == ColW'(OutW - 1))) begin
         rd_addr = '0;
         pix     = '0;
      end
`else
      rd_addr = ADDR_WIDTH'(32'(nxt_row) * WIDTH + 32'(nxt_col));
      pix     = rd_data;
`endif
   end

   // Next-state: start loads pixel (0,0); each accepted beat loads the next or ends
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStream;
               row_d   = '0;
               col_d   = '0;
               data_d  = pix;
               valid_d = 1'b1;
               last_d  = nxt_last;
            end
         end
         StStream: begin
            if (valid_q && strm.ready_in && last_q) begin
               state_d = StDone;
               valid_d = 1'b0;
               last_d  = 1'b0;
            end else if ((!valid_q || strm.ready_in) && !last_q) begin
               row_d   = nxt_row;
               col_d   = nxt_col;
               data_d  = pix;
               valid_d = 1'b1;
               last_d  = nxt_last;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset (storage untouched)
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         col_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign strm.data_out  = data_q;
   assign strm.valid_out = valid_q;
   assign strm.last_out  = last_q;
   assign busy           = (state_q == StStream);
   assign done           = (state_q == StDone);

endmodule

// File: tb/tb_fm_stream_reader.sv
// Directed bench for fm_stream_reader; expectations follow FM_ZERO_PAD_EN if defined.
`timescale 1ns/1ps
module tb_fm_stream_reader;
   import cnn_params_pkg::*;

   localparam int W  = 7;
   localparam int H  = 7;
`ifdef FM_ZERO_PAD_EN
   localparam int OW = W + 2;
   localparam int OH = H + 2;
`else
   localparam int OW = W;
   localparam int OH = H;
`endif
   localparam int N = OW * OH;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [5:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   fm_stream_reader_if #(.DATA_WIDTH(32)) strm_if ();

   fm_stream_reader #(
      .DATA_WIDTH (32),
      .WIDTH      (W),
      .HEIGHT     (H),
      .ADDR_WIDTH (6)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .strm    (strm_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Storage holds value a at address a; beat k maps back to a stored address
   function automatic logic [31:0] exp_pix(input int k);
      int r;
      int c;
      r = k / OW;
      c = k % OW;
`ifdef FM_ZERO_PAD_EN
      if (r == 0 || r == OH - 1 || c == 0 || c == OW - 1) return 32'd0;
      return 32'((r - 1) * W + (c - 1));
`else
      return 32'(r * W + c);
`endif
   endfunction

   task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                            input int poke_at, input int abort_at);
      int b;
      int cyc;
      int stall_left;
      int hold;
      int done_cyc;
      bit xfer;
      b = 0;
      cyc = 0;
      stall_left = stall_len;
      hold = 0;
      done_cyc = -1;
      strm_if.ready_in = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq({tag, " busy after start"}, 32'(busy), 32'd1);
      check_eq({tag, " valid after start"}, 32'(strm_if.valid_out), 32'd1);
      while (cyc < N + 64) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (abort_at >= 0 && b == abort_at) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            check_eq({tag, " valid after reset"}, 32'(strm_if.valid_out), 32'd0);
            check_eq({tag, " busy after reset"}, 32'(busy), 32'd0);
            check_eq({tag, " done after reset"}, 32'(done), 32'd0);
            return;
         end
         check_eq({tag, " valid (no bubble)"}, 32'(strm_if.valid_out), 32'd1);
         check_eq({tag, $sformatf(" data beat %0d", b)}, strm_if.data_out, exp_pix(b));
         check_eq({tag, $sformatf(" last beat %0d", b)}, 32'(strm_if.last_out),
                  32'(b == N - 1));
         if (b == stall_at) hold++;
         if (b == stall_at && stall_left > 0) begin
            strm_if.ready_in = 1'b0;
            stall_left--;
         end else begin
            strm_if.ready_in = 1'b1;
         end
         if (b == poke_at) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 6'd3;
            wr_data = 32'd99;
         end
         xfer = strm_if.valid_out && strm_if.ready_in;
         tick();
         cyc++;
         start = 1'b0;
         wr_en = 1'b0;
         if (xfer) b++;
      end
      check_eq({tag, " beat count"}, 32'(b), 32'(N));
      check_eq({tag, " done cycle"}, 32'(done_cyc), 32'(N + stall_len));
      check_eq({tag, " busy low with done"}, 32'(busy), 32'd0);
      if (stall_at >= 0) check_eq({tag, " held cycles"}, 32'(hold), 32'(stall_len + 1));
      strm_if.ready_in = 1'b1;
      tick();
      check_eq({tag, " done one cycle"}, 32'(done), 32'd0);
      check_eq({tag, " idle busy"}, 32'(busy), 32'd0);
      check_eq({tag, " idle valid"}, 32'(strm_if.valid_out), 32'd0);
   endtask

   initial begin
      strm_if.ready_in = 1'b1;
      rst = 1'b0;
      tick();
      tick();
      check_eq("reset data_out", strm_if.data_out, 32'd0);
      check_eq("reset valid_out", 32'(strm_if.valid_out), 32'd0);
      check_eq("reset last_out", 32'(strm_if.last_out), 32'd0);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset done", 32'(done), 32'd0);
      rst = 1'b1;

      for (int a = 0; a < W * H; a++) begin
         wr_en   = 1'b1;
         wr_addr = 6'(a);
         wr_data = 32'(a);
         tick();
      end
      wr_en = 1'b0;

      run_frame("plain", -1, 0, -1, -1);
      run_frame("stall", 5, 3, -1, -1);
      run_frame("poke", -1, 0, 20, -1);
      run_frame("rerun", -1, 0, -1, -1);
      run_frame("abort", -1, 0, -1, 30);
      run_frame("restart", -1, 0, -1, -1);

      wr_en   = 1'b1;
      wr_addr = 6'd60;
      wr_data = 32'd7;
      tick();
      wr_en = 1'b0;
      run_frame("oob write", -1, 0, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fm_stream_reader.md
# fm_stream_reader

Raster-order feature-map streamer that feeds the 3x3 `line_buffer` window generator. Holds one WIDTH x HEIGHT feature map in a small local register array, loaded through a random-access write port. On `start`, streams the map out one pixel per handshake, row-major. It is the producer end of the pixel stream that `line_buffer` consumes through `data_in`/`valid_in`.

## Interface
- `DATA_WIDTH`, 32, pixel/word width
- `WIDTH`, 7, map columns
- `HEIGHT`, 7, map rows
- `ADDR_WIDTH`, 6, write-address width; must satisfy 2^ADDR_WIDTH >= WIDTH*HEIGHT

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `wr_en`  in  1  write strobe into local map storage
- `wr_addr`  in  ADDR_WIDTH  linear address, row*WIDTH+col
- `wr_data`  in  DATA_WIDTH  pixel to store
- `start`  in  1  one-cycle request to stream the stored map
- `ready_in`  in  1  downstream accepts `data_out` this cycle (tie high for `line_buffer`)
- `data_out`  out  DATA_WIDTH  current pixel
- `valid_out`  out  1  `data_out` valid
- `last_out`  out  1  marks final pixel of the frame, qualified by `valid_out`
- `busy`  out  1  streaming in progress
- `done`  out  1  one-cycle pulse after the final pixel is accepted

## Operation
- Storage: WIDTH*HEIGHT words, written on `clk` when `wr_en` is high and state is IDLE; combinational read. Storage is not cleared by reset.
- Writes with `wr_addr` >= WIDTH*HEIGHT are dropped. Writes while `busy` is high are dropped.
- FSM states:
  - IDLE: `start`=1 clears the row/col counters and goes to STREAM.
  - STREAM: issues pixels. After the handshake on the last pixel, goes to DONE.
  - DONE: asserts `done` for exactly one cycle, then returns to IDLE.
- `start` in STREAM or DONE is ignored.
- Handshake: a beat transfers when `valid_out && ready_in`. The output register reloads when `!valid_out || ready_in` and pixels remain.
- While `valid_out && !ready_in`, `data_out`, `last_out` and `valid_out` hold stable.
- Counters: `col` wraps 0..OUT_W-1, incrementing `row` on wrap. `row` runs 0..OUT_H-1. The pixel index is never exposed.
- Reset mid-stream: next cycle is IDLE; `valid_out`, `last_out`, `busy`, `done` are 0; stored map is retained.
- Reset values: `data_out`=0, `valid_out`=0, `last_out`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled high at edge E0: `busy`=1 and `valid_out`=1 with pixel (0,0) after E0.
- With `ready_in` held high, beat k is presented in cycle k+1. The stream has no bubbles: N beats occupy N consecutive cycles.
- `last_out` is high only on beat N-1.
- `done` and `busy`=0 both occur in the cycle after the last handshake.
- A new `start` is accepted in the cycle after `done`.
- N = OUT_W*OUT_H.

## Configuration
- Macro `FM_ZERO_PAD_EN`.
- Defined:
  - OUT_W = WIDTH+2 and OUT_H = HEIGHT+2.
  - A one-pixel border of zeros surrounds the map. Stored pixel (r,c) appears at output position (r+1,c+1).
  - Border positions never read storage.
  - The 3x3 convolution downstream then preserves WIDTH x HEIGHT.
- Undefined: OUT_W = WIDTH, OUT_H = HEIGHT, and no padding logic is present.

## Structure
- Shared package `cnn_params_pkg` holds:
  - DATA_WIDTH/WIDTH/HEIGHT defaults, also used by `line_buffer`.
  - The FSM state encoding (IDLE=0, STREAM=1, DONE=2).
  - The OUT_W/OUT_H derivation.
- One sub-module, `fm_mem`: storage array with synchronous write port and combinational read port, parameterised by DATA_WIDTH and depth.

## Test plan
- Load addr a with value a (0..48), `start`, `ready_in`=1 -> 49 consecutive beats with values 0..48; `last_out` on value 48; `done` one cycle later; `busy` low with `done`.
- Same load, `ready_in` low for 3 cycles while beat 5 is presented -> `data_out`=5 held for 4 cycles, no beat lost or duplicated; total 49 beats, `done` 3 cycles later than the no-stall run.
- `FM_ZERO_PAD_EN`, same load -> 81 beats; beats 0..9 are 0; beat 10 = 0 (stored (0,0)); beat 11 = 1; beat 16 = 6; beat 17 = 0 (border); beat 80 = 0 with `last_out`.
- `start` pulsed again at beat 20 and `wr_en` with addr 3, value 99 during streaming -> stream unaffected; rerun after `done` still yields 3 at beat 3.
- `rst` low at beat 30 -> next cycle `valid_out`=`busy`=`done`=0; new `start` restarts from value 0, proving storage retained.
- Write to `wr_addr`=60 value 7 -> no storage change; a full stream matches the prior frame.
